// File: rtl/turf_pkg.sv
// Shared definitions for the turf RAM: geometry, cell colours and the
// arbiter state encoding.
package turf_pkg;

    // RAM geometry: address is {x[7:0], y[6:0]}, each cell holds a colour.
    localparam int ADDR_W = 15;
    localparam int DATA_W = 3;

    // Cell colours.
    localparam logic [2:0] COL_EMPTY = 3'b000;
    localparam logic [2:0] COL_P1    = 3'b001;
    localparam logic [2:0] COL_P2    = 3'b010;
    localparam logic [2:0] COL_P3    = 3'b100;
    localparam logic [2:0] COL_P4    = 3'b110;
    localparam logic [2:0] COL_DEAD  = 3'b111;

    // Arbiter states: serve the requesters, or sweep the whole board.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/turf_ram_clear.sv
// Full-board clear sweep counter. A start pulse rewinds the counter to 0 and
// arms the sweep; the counter then advances one address per cycle and the
// sweep ends after the last address. done is high during the final write.
module turf_ram_clear #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic              active,
    output logic              done
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              active_q, active_d;

    // Next counter value: rewind on start, step while sweeping, stop after the top address.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
                active_d = 1'b0;
            end
        end
    end

    // Sweep registers; an asynchronous reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign addr   = cnt_q;
    assign active = active_q;
    assign done   = active_q && (cnt_q == '1);

endmodule

// File: rtl/turf_ram_arbiter.sv
// Single owner of the turf RAM port. Arbitrates the game and VGA requesters
// (game first, VGA promoted after VGA_MAX_WAIT denied cycles) and runs the
// full-board clear sweep.
// Build option: define TURF_CLEAR_ON_RESET_EN to sweep the board after every reset.
//
// Handshake: a requester holds req (and its address/data) until it sees gnt
// high in the same cycle; the access happens in that cycle. For a read, rvalid
// is high exactly one cycle later with rdata; rdata is 0 whenever rvalid is low.
module turf_ram_arbiter #(
    parameter int                ADDR_W       = 15,
    parameter int                DATA_W       = 3,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = 3'b000,
    parameter int                VGA_MAX_WAIT = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_gnt,
    output logic              g_rvalid,
    output logic [DATA_W-1:0] g_rdata,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_gnt,
    output logic              v_rvalid,
    output logic [DATA_W-1:0] v_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              state_dbg
);

    import turf_pkg::*;

    localparam int                WAIT_W   = $clog2(VGA_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VGA_MAX_WAIT);

`ifdef TURF_CLEAR_ON_RESET_EN
    localparam logic CLR_PEND_RST = 1'b1;
`else
    localparam logic CLR_PEND_RST = 1'b0;
`endif

    arb_state_t        state_q, state_d;
    logic              clr_pend_q, clr_pend_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              g_rvalid_q, g_rvalid_d;
    logic              v_rvalid_q, v_rvalid_d;
    logic [ADDR_W-1:0] addr_q;

    logic              clr_start;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_active;
    logic              clr_done;
    logic              serve;
    logic              sweeping;
    logic              vga_prio;

    turf_ram_clear #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .start  (clr_start),
        .addr   (clr_addr),
        .active (clr_active),
        .done   (clr_done)
    );

    // Grant decision and RAM port muxing. Grants are masked by resetn so the
    // port is quiet for the whole time reset is asserted.
    always_comb begin
        serve    = resetn && (state_q == ST_IDLE) && !clr_pend_q;
        sweeping = (state_q == ST_CLEAR) && clr_active;
        vga_prio = (wait_q == WAIT_MAX);
        g_gnt    = serve && g_req && !(vga_prio && v_req);
        v_gnt    = serve && v_req && !(g_req && !vga_prio);

        ram_address = addr_q;
        ram_data    = g_wdata;
        ram_wren    = 1'b0;
        if (sweeping) begin
            ram_address = clr_addr;
            ram_data    = CLEAR_VAL;
            ram_wren    = 1'b1;
        end else if (g_gnt) begin
            ram_address = g_addr;
            ram_wren    = g_we;
        end else if (v_gnt) begin
            ram_address = v_addr;
        end
    end

    // Next-state logic: pending clear launches the sweep, sweep end returns to IDLE.
    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        clr_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_pend_q) begin
                    state_d   = ST_CLEAR;
                    clr_start = 1'b1;
                end else if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_done) begin
                    state_d    = ST_IDLE;
                    clr_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // VGA starvation counter and read-return flags.
    always_comb begin
        wait_d = wait_q;
        if (state_q == ST_CLEAR || !v_req || v_gnt) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        g_rvalid_d = g_gnt && !g_we;
        v_rvalid_d = v_gnt;
    end

    // State registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= CLR_PEND_RST;
            wait_q     <= '0;
            g_rvalid_q <= 1'b0;
            v_rvalid_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            wait_q     <= wait_d;
            g_rvalid_q <= g_rvalid_d;
            v_rvalid_q <= v_rvalid_d;
            addr_q     <= ram_address;
        end
    end

    assign clear_busy = clr_pend_q || (state_q == ST_CLEAR);
    assign g_rvalid   = g_rvalid_q;
    assign v_rvalid   = v_rvalid_q;
    assign g_rdata    = g_rvalid_q ? ram_q : '0;
    assign v_rdata    = v_rvalid_q ? ram_q : '0;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_turf_ram_arbiter.sv
// Testbench for turf_ram_arbiter: behavioural RAM model, table of single-cycle
// vectors, then hand-written sequences for starvation, clear sweep and reset abort.
module tb_turf_ram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear_req;
    logic        clear_busy;
    logic        g_req, g_we;
    logic [14:0] g_addr;
    logic [2:0]  g_wdata;
    logic        g_gnt, g_rvalid;
    logic [2:0]  g_rdata;
    logic        v_req;
    logic [14:0] v_addr;
    logic        v_gnt, v_rvalid;
    logic [2:0]  v_rdata;
    logic [14:0] ram_address;
    logic [2:0]  ram_data;
    logic        ram_wren;
    logic [2:0]  ram_q;
    logic        state_dbg;

    always #5 clk = ~clk;

`ifdef TURF_CLEAR_ON_RESET_EN
    localparam logic BUSY_RST    = 1'b1;
    localparam int   POST_RST_WR = 39;
`else
    localparam logic BUSY_RST    = 1'b0;
    localparam int   POST_RST_WR = 0;
`endif

    turf_ram_arbiter dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .g_req       (g_req),
        .g_we        (g_we),
        .g_addr      (g_addr),
        .g_wdata     (g_wdata),
        .g_gnt       (g_gnt),
        .g_rvalid    (g_rvalid),
        .g_rdata     (g_rdata),
        .v_req       (v_req),
        .v_addr      (v_addr),
        .v_gnt       (v_gnt),
        .v_rvalid    (v_rvalid),
        .v_rdata     (v_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .state_dbg   (state_dbg)
    );

    // RAM macro model: synchronous write, one-cycle registered read.
    logic [2:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        g_req;
        logic        g_we;
        logic [14:0] g_addr;
        logic [2:0]  g_wdata;
        logic        v_req;
        logic [14:0] v_addr;
        logic        e_g_gnt;
        logic        e_v_gnt;
        logic        e_wren;
        logic [14:0] e_addr;
        logic [2:0]  e_data;
        logic        e_g_rvalid;
        logic [2:0]  e_g_rdata;
        logic        e_v_rvalid;
        logic [2:0]  e_v_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic gr, input logic gw, input logic [14:0] ga, input logic [2:0] gd,
        input logic vr, input logic [14:0] va,
        input logic egg, input logic evg, input logic ew, input logic [14:0] ea,
        input logic [2:0] ed, input logic egv, input logic [2:0] egd,
        input logic evv, input logic [2:0] evd);
        vec_t v;
        v.g_req = gr; v.g_we = gw; v.g_addr = ga; v.g_wdata = gd;
        v.v_req = vr; v.v_addr = va;
        v.e_g_gnt = egg; v.e_v_gnt = evg; v.e_wren = ew; v.e_addr = ea; v.e_data = ed;
        v.e_g_rvalid = egv; v.e_g_rdata = egd; v.e_v_rvalid = evv; v.e_v_rdata = evd;
        return v;
    endfunction

    vec_t vecs[12];

    int   n_wr, first_cyc, fall_cyc, seq_err, gnt_err, idle_err, nonzero, wr_cnt;
    logic hit;

    initial begin
        //             greq we  g_addr    wdata  vreq v_addr    g  v  wr addr      data   grv grd    vrv vrd
        vecs[0]  = mk(1, 1, 15'h4F77, 3'b001, 0, 15'h0000, 1, 0, 1, 15'h4F77, 3'b001, 0, 3'b000, 0, 3'b000);
        vecs[1]  = mk(1, 1, 15'h0001, 3'b010, 0, 15'h0000, 1, 0, 1, 15'h0001, 3'b010, 0, 3'b000, 0, 3'b000);
        vecs[2]  = mk(1, 0, 15'h0001, 3'b000, 0, 15'h0000, 1, 0, 0, 15'h0001, 3'b000, 0, 3'b000, 0, 3'b000);
        vecs[3]  = mk(0, 0, 15'h0000, 3'b000, 0, 15'h0000, 0, 0, 0, 15'h0001, 3'b000, 1, 3'b010, 0, 3'b000);
        vecs[4]  = mk(0, 0, 15'h0000, 3'b000, 1, 15'h4F77, 0, 1, 0, 15'h4F77, 3'b000, 0, 3'b000, 0, 3'b000);
        vecs[5]  = mk(1, 0, 15'h4F77, 3'b000, 1, 15'h0001, 1, 0, 0, 15'h4F77, 3'b000, 0, 3'b000, 1, 3'b001);
        vecs[6]  = mk(0, 0, 15'h0000, 3'b000, 0, 15'h0000, 0, 0, 0, 15'h4F77, 3'b000, 1, 3'b001, 0, 3'b000);
        vecs[7]  = mk(1, 1, 15'h7FFF, 3'b111, 0, 15'h0000, 1, 0, 1, 15'h7FFF, 3'b111, 0, 3'b000, 0, 3'b000);
        vecs[8]  = mk(0, 0, 15'h0000, 3'b000, 1, 15'h7FFF, 0, 1, 0, 15'h7FFF, 3'b000, 0, 3'b000, 0, 3'b000);
        vecs[9]  = mk(0, 0, 15'h0000, 3'b000, 0, 15'h0000, 0, 0, 0, 15'h7FFF, 3'b000, 0, 3'b000, 1, 3'b111);
        vecs[10] = mk(1, 1, 15'h0000, 3'b110, 1, 15'h0000, 1, 0, 1, 15'h0000, 3'b110, 0, 3'b000, 0, 3'b000);
        vecs[11] = mk(0, 0, 15'h0000, 3'b000, 0, 15'h0000, 0, 0, 0, 15'h0000, 3'b000, 0, 3'b000, 0, 3'b000);

        for (int i = 0; i < 32768; i++) mem[i] = 3'b101;

        // ---------------- reset ----------------
        resetn = 1'b0; clear_req = 1'b0;
        g_req = 1'b1; g_we = 1'b1; g_addr = 15'h0123; g_wdata = 3'b011;
        v_req = 1'b0; v_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_g_gnt",      32'(g_gnt), 0);
        chk("rst_v_gnt",      32'(v_gnt), 0);
        chk("rst_wren",       32'(ram_wren), 0);
        chk("rst_address",    32'(ram_address), 0);
        chk("rst_g_rvalid",   32'(g_rvalid), 0);
        chk("rst_v_rvalid",   32'(v_rvalid), 0);
        chk("rst_clear_busy", 32'(clear_busy), 32'(BUSY_RST));
        @(negedge clk);
        resetn = 1'b1; g_req = 1'b0; g_we = 1'b0;
`ifdef TURF_CLEAR_ON_RESET_EN
        for (int i = 0; i < 40000 && clear_busy; i++) @(negedge clk);
        chk("init_sweep_done", 32'(clear_busy), 0);
`endif

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            g_req = vecs[i].g_req; g_we = vecs[i].g_we; g_addr = vecs[i].g_addr;
            g_wdata = vecs[i].g_wdata; v_req = vecs[i].v_req; v_addr = vecs[i].v_addr;
            #1;
            chk($sformatf("vec%0d_g_gnt", i),    32'(g_gnt),       32'(vecs[i].e_g_gnt));
            chk($sformatf("vec%0d_v_gnt", i),    32'(v_gnt),       32'(vecs[i].e_v_gnt));
            chk($sformatf("vec%0d_wren", i),     32'(ram_wren),    32'(vecs[i].e_wren));
            chk($sformatf("vec%0d_address", i),  32'(ram_address), 32'(vecs[i].e_addr));
            if (vecs[i].e_wren) chk($sformatf("vec%0d_data", i), 32'(ram_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_g_rvalid", i), 32'(g_rvalid),    32'(vecs[i].e_g_rvalid));
            chk($sformatf("vec%0d_g_rdata", i),  32'(g_rdata),     32'(vecs[i].e_g_rdata));
            chk($sformatf("vec%0d_v_rvalid", i), 32'(v_rvalid),    32'(vecs[i].e_v_rvalid));
            chk($sformatf("vec%0d_v_rdata", i),  32'(v_rdata),     32'(vecs[i].e_v_rdata));
            @(negedge clk);
        end

        // ---------------- VGA starvation: both ports held ----------------
        g_req = 1'b1; g_we = 1'b0; g_addr = 15'h1234;
        v_req = 1'b1; v_addr = 15'h2345;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve%0d_g_gnt", i), 32'(g_gnt), (i % 5 == 4) ? 0 : 1);
            chk($sformatf("starve%0d_v_gnt", i), 32'(v_gnt), (i % 5 == 4) ? 1 : 0);
            chk($sformatf("starve%0d_addr", i),  32'(ram_address), (i % 5 == 4) ? 32'h2345 : 32'h1234);
            @(negedge clk);
        end
        g_req = 1'b0; v_req = 1'b0;
        @(negedge clk);

        // ---------------- full clear sweep ----------------
        clear_req = 1'b1;
        #1;
        chk("clr_n_busy", 32'(clear_busy), 0);
        @(negedge clk);
        clear_req = 1'b0;
        g_req = 1'b1; g_we = 1'b0; g_addr = 15'h4F77;
        v_req = 1'b1; v_addr = 15'h0001;
        #1;
        chk("clr_n1_busy",  32'(clear_busy), 1);
        chk("clr_n1_g_gnt", 32'(g_gnt), 0);
        chk("clr_n1_v_gnt", 32'(v_gnt), 0);
        chk("clr_n1_wren",  32'(ram_wren), 0);
        n_wr = 0; first_cyc = -1; fall_cyc = -1; seq_err = 0; gnt_err = 0; idle_err = 0;
        for (int cyc = 2; cyc < 40000; cyc++) begin
            @(negedge clk);
            clear_req = (n_wr == 100);
            #1;
            if (!clear_busy) begin
                fall_cyc = cyc;
                break;
            end
            if (g_gnt || v_gnt) gnt_err++;
            if (ram_wren) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (ram_address != n_wr[14:0] || ram_data != 3'b000) seq_err++;
                n_wr++;
            end else begin
                idle_err++;
            end
        end
        clear_req = 1'b0;
        chk("clr_first_write_cycle", 32'(first_cyc), 2);
        chk("clr_write_count",       32'(n_wr), 32768);
        chk("clr_busy_fall_cycle",   32'(fall_cyc), 32770);
        chk("clr_addr_data_errors",  32'(seq_err), 0);
        chk("clr_grant_errors",      32'(gnt_err), 0);
        chk("clr_gap_errors",        32'(idle_err), 0);
        nonzero = 0;
        for (int i = 0; i < 32768; i++) if (mem[i] != 3'b000) nonzero++;
        chk("clr_board_empty",       32'(nonzero), 0);
        // First cycle after the sweep: wait counter was held at 0, so game wins.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) #1;
            chk($sformatf("post_clr%0d_g_gnt", i), 32'(g_gnt), (i == 4) ? 0 : 1);
            chk($sformatf("post_clr%0d_v_gnt", i), 32'(v_gnt), (i == 4) ? 1 : 0);
            if (i == 1) begin
                chk("post_clr_g_rvalid", 32'(g_rvalid), 1);
                chk("post_clr_g_rdata",  32'(g_rdata), 0);
            end
            @(negedge clk);
        end
        g_req = 1'b0; v_req = 1'b0;
        @(negedge clk);

        // ---------------- reset mid-sweep ----------------
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (ram_wren && ram_address == 15'd1000) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reached_1000", 32'(hit), 1);
        #1;
        resetn = 1'b0; g_req = 1'b1; g_we = 1'b1; g_addr = 15'h0042;
        #1;
        chk("abort_wren",       32'(ram_wren), 0);
        chk("abort_address",    32'(ram_address), 0);
        chk("abort_g_gnt",      32'(g_gnt), 0);
        chk("abort_v_gnt",      32'(v_gnt), 0);
        chk("abort_g_rvalid",   32'(g_rvalid), 0);
        chk("abort_clear_busy", 32'(clear_busy), 32'(BUSY_RST));
        @(negedge clk);
        resetn = 1'b1; g_req = 1'b0; g_we = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ram_wren) wr_cnt++;
            @(negedge clk);
        end
        chk("post_abort_writes", 32'(wr_cnt), 32'(POST_RST_WR));
        chk("post_abort_busy",   32'(clear_busy), 32'(BUSY_RST));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
